// File: rtl/udma_generic_tx_if_32b.sv
// udma_generic_tx_if_32b
// Register front end and output FIFO for a 32-bit uDMA TX channel.
// Words from the uDMA are buffered and streamed to a peripheral.
// Words sent are counted per transfer, and tx_done_o pulses once per
// completed transfer.
// Optional feature macro: UDMA_TX_BYTESWAP_EN adds a CFG bit8 byte-swap control.
module udma_generic_tx_if_32b #(
    parameter int L2_AWIDTH_NOAL  = 12,
    parameter int UDMA_TRANS_SIZE = 16,
    parameter int TRANS_SIZE      = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [31:0]                cfg_data_i,
    input  logic [4:0]                 cfg_addr_i,
    input  logic                       cfg_valid_i,
    input  logic                       cfg_rwn_i,
    output logic [31:0]                cfg_data_o,
    output logic                       cfg_ready_o,
    output logic [L2_AWIDTH_NOAL-1:0]  cfg_tx_startaddr_o,
    output logic [UDMA_TRANS_SIZE-1:0] cfg_tx_size_o,
    output logic [1:0]                 cfg_tx_datasize_o,
    output logic                       cfg_tx_continuous_o,
    output logic                       cfg_tx_en_o,
    output logic                       cfg_tx_clr_o,
    input  logic                       cfg_tx_en_i,
    input  logic                       cfg_tx_pending_i,
    input  logic [L2_AWIDTH_NOAL-1:0]  cfg_tx_curr_addr_i,
    input  logic [UDMA_TRANS_SIZE-1:0] cfg_tx_bytes_left_i,
    input  logic [31:0]                data_tx_i,
    input  logic                       data_tx_valid_i,
    output logic                       data_tx_ready_o,
    output logic [31:0]                tx_data_o,
    output logic                       tx_valid_o,
    input  logic                       tx_ready_i,
    output logic                       tx_done_o
);
    localparam int SW = TRANS_SIZE - 2;        // size register holds words
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    logic [L2_AWIDTH_NOAL-1:0] r_saddr;
    logic [SW-1:0]             r_size;
    logic                      r_cont, r_en, r_clr, r_swap;
    logic                      cfg_wr;

    logic [31:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, level;
    logic        full, empty, push, pop;
    logic [31:0] head;

    state_t        state_q, state_d;
    logic          run;
    logic [SW-1:0] cnt_q;
    logic          done_q;
    logic          last;
    logic          unused_cfg;

    assign cfg_wr     = cfg_valid_i & ~cfg_rwn_i;
    assign unused_cfg = ^cfg_data_i;

    // cfg register writes; en/clr are single-cycle strobes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_saddr <= '0;
            r_size  <= '0;
            r_cont  <= 1'b0;
            r_en    <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            r_en  <= 1'b0;
            r_clr <= 1'b0;
            if (cfg_wr) begin
                case (cfg_addr_i)
                    5'h00: r_saddr <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
                    5'h01: r_size  <= cfg_data_i[TRANS_SIZE-1:2];
                    5'h02: begin
                        r_cont <= cfg_data_i[0];
                        r_en   <= cfg_data_i[4];
                        r_clr  <= cfg_data_i[5];
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef UDMA_TX_BYTESWAP_EN
    // byte-swap control bit in CFG[8]
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_swap <= 1'b0;
        else if (cfg_wr && cfg_addr_i == 5'h02)
            r_swap <= cfg_data_i[8];
    end
`else
    assign r_swap = 1'b0;
`endif

    assign full  = (level == (AW+1)'(FIFO_DEPTH));
    assign empty = (level == '0);
    assign push  = data_tx_valid_i & ~full;
    assign pop   = ~empty & tx_ready_i;
    assign level = wr_ptr - rd_ptr;

    // FIFO pointers; clr wins over any push/pop in the same cycle
    always_ff @(posedge clk_i) begin
        if (rst_i || r_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage, no reset needed: contents are only visible when level > 0
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= data_tx_i;
    end

    assign head = fifo_mem[rd_ptr[AW-1:0]];
    assign last = ((cnt_q + SW'(1)) == r_size);

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: clr > en > end-of-transfer
    always_comb begin
        state_d = state_q;
        if (r_clr)
            state_d = ST_IDLE;
        else if (r_en)
            state_d = (r_size != '0) ? ST_RUN : ST_IDLE;
        else if (state_q == ST_RUN && pop && last && !r_cont)
            state_d = ST_IDLE;
    end

    // FSM outputs
    always_comb begin
        run = (state_q == ST_RUN);
    end

    // word counter and done strobe
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (r_clr) begin
                cnt_q <= '0;
            end else if (r_en) begin
                cnt_q  <= '0;
                done_q <= (r_size == '0);
            end else if (run && pop) begin
                if (last) begin
                    cnt_q  <= '0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + SW'(1);
                end
            end
        end
    end

    // cfg read mux
    always_comb begin
        cfg_data_o = '0;
        case (cfg_addr_i)
            5'h00: cfg_data_o = 32'(cfg_tx_curr_addr_i);
            5'h01: cfg_data_o = 32'(cfg_tx_bytes_left_i);
            5'h02: begin
                cfg_data_o[0]   = r_cont;
                cfg_data_o[2:1] = 2'b10;
                cfg_data_o[4]   = cfg_tx_en_i;
                cfg_data_o[5]   = cfg_tx_pending_i;
                cfg_data_o[8]   = r_swap;
            end
            5'h03: begin
                cfg_data_o[31]   = run;
                cfg_data_o[23:8] = 16'(cnt_q);
                cfg_data_o[7:0]  = 8'(level);
            end
            default: ;
        endcase
    end

    assign cfg_ready_o         = 1'b1;
    assign cfg_tx_startaddr_o  = r_saddr;
    assign cfg_tx_size_o       = UDMA_TRANS_SIZE'({r_size, 2'b00});
    assign cfg_tx_datasize_o   = 2'b10;
    assign cfg_tx_continuous_o = r_cont;
    assign cfg_tx_en_o         = r_en;
    assign cfg_tx_clr_o        = r_clr;
    assign data_tx_ready_o     = ~full;
    assign tx_valid_o          = ~empty;
    assign tx_data_o           = r_swap ? {head[7:0], head[15:8], head[23:16], head[31:24]} : head;
    assign tx_done_o           = done_q;

endmodule

// File: tb/tb_udma_generic_tx_if_32b.sv
// Bench for udma_generic_tx_if_32b: register table, hand-written corner
// sequences, then random traffic checked cycle by cycle against a
// queue-based transfer model.
module tb_udma_generic_tx_if_32b;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] cfg_data_i = '0;
    logic [4:0]  cfg_addr_i = 5'd3;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_rwn_i = 1'b1;
    logic [31:0] cfg_data_o;
    logic        cfg_ready_o;
    logic [11:0] cfg_tx_startaddr_o;
    logic [15:0] cfg_tx_size_o;
    logic [1:0]  cfg_tx_datasize_o;
    logic        cfg_tx_continuous_o, cfg_tx_en_o, cfg_tx_clr_o;
    logic        cfg_tx_en_i = 1'b0, cfg_tx_pending_i = 1'b0;
    logic [11:0] cfg_tx_curr_addr_i = 12'h5A5;
    logic [15:0] cfg_tx_bytes_left_i = 16'h1234;
    logic [31:0] data_tx_i = '0;
    logic        data_tx_valid_i = 1'b0;
    logic        data_tx_ready_o;
    logic [31:0] tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic        tx_done_o;

    always #5 clk = ~clk;

    udma_generic_tx_if_32b dut (
        .clk_i(clk), .rst_i(rst_i),
        .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i), .cfg_valid_i(cfg_valid_i),
        .cfg_rwn_i(cfg_rwn_i), .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready_o),
        .cfg_tx_startaddr_o(cfg_tx_startaddr_o), .cfg_tx_size_o(cfg_tx_size_o),
        .cfg_tx_datasize_o(cfg_tx_datasize_o), .cfg_tx_continuous_o(cfg_tx_continuous_o),
        .cfg_tx_en_o(cfg_tx_en_o), .cfg_tx_clr_o(cfg_tx_clr_o),
        .cfg_tx_en_i(cfg_tx_en_i), .cfg_tx_pending_i(cfg_tx_pending_i),
        .cfg_tx_curr_addr_i(cfg_tx_curr_addr_i), .cfg_tx_bytes_left_i(cfg_tx_bytes_left_i),
        .data_tx_i(data_tx_i), .data_tx_valid_i(data_tx_valid_i), .data_tx_ready_o(data_tx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .tx_done_o(tx_done_o)
    );

    int n_cmp = 0, n_err = 0, done_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bsw(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // ---------------- transfer model ----------------
    logic [31:0] m_q[$];
    bit m_run, m_cont, m_en_p, m_clr_p, m_done, m_swap;
    int m_cnt, m_words;

    always @(negedge clk) begin
        bit push, pop, nd;
        logic [31:0] hd;
        if (rst_i) begin
            m_q.delete();
            m_run = 0; m_cont = 0; m_en_p = 0; m_clr_p = 0; m_done = 0; m_swap = 0;
            m_cnt = 0; m_words = 0;
        end else begin
            // outputs for the current cycle
            chk("m_dready", data_tx_ready_o, m_q.size() < D);
            chk("m_valid", tx_valid_o, m_q.size() != 0);
            if (m_q.size() != 0) begin
                hd = m_swap ? bsw(m_q[0]) : m_q[0];
                chk("m_data", tx_data_o, hd);
            end
            chk("m_done", tx_done_o, m_done);
            chk("m_en", cfg_tx_en_o, m_en_p);
            chk("m_clr", cfg_tx_clr_o, m_clr_p);
            if (cfg_addr_i == 5'd3 && !(cfg_valid_i && !cfg_rwn_i))
                chk("m_status", cfg_data_o, {m_run, 7'd0, 16'(m_cnt), 8'(m_q.size())});
            if (tx_done_o) done_seen++;
            // advance to the next edge
            push = data_tx_valid_i && (m_q.size() < D);
            pop  = tx_ready_i && (m_q.size() != 0);
            nd = 0;
            if (m_clr_p) begin
                m_q.delete(); m_run = 0; m_cnt = 0;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) m_q.push_back(data_tx_i);
                if (m_en_p) begin
                    m_cnt = 0;
                    if (m_words != 0) m_run = 1;
                    else begin m_run = 0; nd = 1; end
                end else if (m_run && pop) begin
                    if (m_cnt + 1 == m_words) begin
                        nd = 1; m_cnt = 0;
                        if (!m_cont) m_run = 0;
                    end else m_cnt++;
                end
            end
            m_done = nd;
            m_en_p = 0; m_clr_p = 0;
            if (cfg_valid_i && !cfg_rwn_i) begin
                if (cfg_addr_i == 5'd1) m_words = int'(cfg_data_i[15:2]);
                if (cfg_addr_i == 5'd2) begin
                    m_cont = cfg_data_i[0]; m_en_p = cfg_data_i[4]; m_clr_p = cfg_data_i[5];
`ifdef UDMA_TX_BYTESWAP_EN
                    m_swap = cfg_data_i[8];
`endif
                end
            end
        end
    end

    task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cfg_valid_i = 1; cfg_rwn_i = 0; cfg_addr_i = a; cfg_data_i = d;
        @(posedge clk); #1;
        cfg_valid_i = 0; cfg_rwn_i = 1; cfg_addr_i = 5'd3;
    endtask

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        bit          pend, eni;
        logic [31:0] exp_rd;
        logic [11:0] exp_saddr;
        logic [15:0] exp_size;
        bit          exp_cont;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int d0, k;
        bit acc;
        tbl[0]  = '{1, 5'h00, 32'hFFFF_FABC, 0, 0, 32'h0,   12'hABC, 16'h0,  0};
        tbl[1]  = '{1, 5'h01, 32'h0001_0013, 0, 0, 32'h0,   12'hABC, 16'h10, 0};
        tbl[2]  = '{1, 5'h02, 32'h0000_0001, 0, 0, 32'h0,   12'hABC, 16'h10, 1};
        tbl[3]  = '{0, 5'h02, 32'h0,         1, 1, 32'h35,  12'hABC, 16'h10, 1};
        tbl[4]  = '{0, 5'h00, 32'h0,         0, 0, 32'h5A5, 12'hABC, 16'h10, 1};
        tbl[5]  = '{0, 5'h01, 32'h0,         0, 0, 32'h1234,12'hABC, 16'h10, 1};
        tbl[6]  = '{0, 5'h03, 32'h0,         0, 0, 32'h0,   12'hABC, 16'h10, 1};
        tbl[7]  = '{1, 5'h1F, 32'hFFFF_FFFF, 0, 0, 32'h0,   12'hABC, 16'h10, 1};
        tbl[8]  = '{0, 5'h1F, 32'h0,         0, 0, 32'h0,   12'hABC, 16'h10, 1};
        tbl[9]  = '{1, 5'h02, 32'h0,         0, 0, 32'h0,   12'hABC, 16'h10, 0};
        tbl[10] = '{0, 5'h02, 32'h0,         1, 0, 32'h24,  12'hABC, 16'h10, 0};
        tbl[11] = '{0, 5'h02, 32'h0,         0, 1, 32'h14,  12'hABC, 16'h10, 0};

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en", cfg_tx_en_o, 0);
        chk("rst_clr", cfg_tx_clr_o, 0);
        chk("rst_saddr", 32'(cfg_tx_startaddr_o), 0);
        chk("rst_size", 32'(cfg_tx_size_o), 0);
        chk("rst_cont", cfg_tx_continuous_o, 0);
        chk("rst_dsize", 32'(cfg_tx_datasize_o), 2);
        chk("rst_cready", cfg_ready_o, 1);
        chk("rst_valid", tx_valid_o, 0);
        chk("rst_dready", data_tx_ready_o, 1);
        chk("rst_done", tx_done_o, 0);
        chk("rst_status", cfg_data_o, 0);
        @(posedge clk); #1 rst_i = 0;

        // register table
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            cfg_valid_i = 1; cfg_rwn_i = !tbl[i].wr; cfg_addr_i = tbl[i].addr;
            cfg_data_i = tbl[i].data; cfg_tx_pending_i = tbl[i].pend; cfg_tx_en_i = tbl[i].eni;
            @(negedge clk);
            if (!tbl[i].wr) chk($sformatf("tbl%0d_rd", i), cfg_data_o, tbl[i].exp_rd);
            @(posedge clk); #1;
            cfg_valid_i = 0; cfg_rwn_i = 1; cfg_addr_i = 5'd3; cfg_tx_pending_i = 0; cfg_tx_en_i = 0;
            @(negedge clk);
            chk($sformatf("tbl%0d_saddr", i), 32'(cfg_tx_startaddr_o), 32'(tbl[i].exp_saddr));
            chk($sformatf("tbl%0d_size", i), 32'(cfg_tx_size_o), 32'(tbl[i].exp_size));
            chk($sformatf("tbl%0d_cont", i), cfg_tx_continuous_o, tbl[i].exp_cont);
        end

        // single transfer of 4 words
        cfg_wr(5'h01, 32'h10);
        cfg_wr(5'h02, 32'h10);
        @(negedge clk) chk("a_en_pulse", cfg_tx_en_o, 1);
        @(posedge clk); #1;
        d0 = done_seen; tx_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            data_tx_valid_i = 1; data_tx_i = 32'hA000_0000 + i;
            @(posedge clk); #1;
        end
        data_tx_valid_i = 0;
        repeat (8) @(posedge clk); #1;
        chk("a_done_cnt", done_seen - d0, 1);
        @(negedge clk) chk("a_idle", cfg_data_o[31], 0);

        // fill the FIFO with the sink stalled
        @(posedge clk); #1;
        tx_ready_i = 0; k = 0; data_tx_valid_i = 1; data_tx_i = 32'hB0;
        for (int t = 0; t < 20 && k < 4; t++) begin
            @(negedge clk) acc = data_tx_ready_o;
            @(posedge clk); #1;
            if (acc) begin k++; data_tx_i = 32'hB0 + k; end
        end
        chk("b_accepted", k, 4);
        @(negedge clk);
        chk("b_full_ready", data_tx_ready_o, 0);
        chk("b_level", cfg_data_o[7:0], 4);
        @(posedge clk); #1 tx_ready_i = 1;
        @(negedge clk) chk("b_full_pop_ready", data_tx_ready_o, 0);
        @(posedge clk); #1 tx_ready_i = 0;
        @(negedge clk) chk("b_ready_after_pop", data_tx_ready_o, 1);
        @(posedge clk); #1 data_tx_valid_i = 0;
        @(negedge clk);
        chk("b_level5", cfg_data_o[7:0], 4);
        chk("b_head", tx_data_o, 32'hB1);
        @(posedge clk); #1 tx_ready_i = 1;
        repeat (6) @(posedge clk); #1 tx_ready_i = 0;

        // continuous mode, 2-word transfers
        cfg_wr(5'h01, 32'h8);
        cfg_wr(5'h02, 32'h11);
        @(posedge clk); #1;
        d0 = done_seen; tx_ready_i = 1;
        for (int i = 0; i < 6; i++) begin
            data_tx_valid_i = 1; data_tx_i = 32'hC000_0000 + i;
            @(posedge clk); #1;
        end
        data_tx_valid_i = 0;
        repeat (8) @(posedge clk); #1;
        chk("c_done_cnt", done_seen - d0, 3);
        @(negedge clk) chk("c_run", cfg_data_o[31], 1);
        cfg_wr(5'h02, 32'h20);

        // clr in the middle of a transfer
        cfg_wr(5'h01, 32'h10);
        cfg_wr(5'h02, 32'h10);
        @(posedge clk); #1;
        tx_ready_i = 0; data_tx_valid_i = 1;
        for (int i = 0; i < 3; i++) begin
            data_tx_i = 32'hD0 + i;
            @(posedge clk); #1;
        end
        data_tx_valid_i = 0;
        d0 = done_seen;
        cfg_wr(5'h02, 32'h20);
        @(negedge clk) chk("d_clr_pulse", cfg_tx_clr_o, 1);
        @(negedge clk);
        chk("d_clr_off", cfg_tx_clr_o, 0);
        chk("d_status", cfg_data_o, 0);
        chk("d_valid", tx_valid_o, 0);
        repeat (4) @(posedge clk); #1;
        chk("d_no_done", done_seen - d0, 0);

        // enable with size 0
        cfg_wr(5'h01, 32'h0);
        cfg_wr(5'h02, 32'h10);
        @(negedge clk);
        @(negedge clk) chk("e_done", tx_done_o, 1);
        @(negedge clk) chk("e_done_off", tx_done_o, 0);

`ifdef UDMA_TX_BYTESWAP_EN
        cfg_wr(5'h02, 32'h110);
        @(posedge clk); #1;
        data_tx_valid_i = 1; data_tx_i = 32'h1122_3344;
        @(posedge clk); #1 data_tx_valid_i = 0;
        @(negedge clk) chk("s_swap", tx_data_o, 32'h4433_2211);
        cfg_wr(5'h02, 32'h20);
`endif

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            int r;
            @(posedge clk); #1;
            cfg_valid_i = 0; cfg_rwn_i = 1; cfg_addr_i = 5'd3;
            data_tx_valid_i = ($urandom % 3) != 0;
            data_tx_i = $urandom;
            tx_ready_i = ($urandom % 3) != 0;
            r = $urandom % 40;
            if (r == 0) begin
                cfg_valid_i = 1; cfg_rwn_i = 0; cfg_addr_i = 5'd2;
                cfg_data_i = {23'($urandom), 1'b0, 2'b00, ($urandom % 8) == 0,
                              1'($urandom), 3'b000, 1'($urandom)};
`ifdef UDMA_TX_BYTESWAP_EN
                cfg_data_i[8] = 1'($urandom);
`endif
            end else if (r == 1) begin
                cfg_valid_i = 1; cfg_rwn_i = 0; cfg_addr_i = 5'd1;
                cfg_data_i = {16'($urandom), 14'($urandom % 5), 2'($urandom)};
            end
        end
        @(posedge clk); #1;
        cfg_valid_i = 0; cfg_rwn_i = 1; cfg_addr_i = 5'd3;
        data_tx_valid_i = 0; tx_ready_i = 0;
        @(negedge clk);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
